// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared ISA constants, ALU codes and controller state codes
//                for the multicycle MIPS control slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_multi_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multi_control_if
//  Description : Controller <-> datapath bundle: IR fields and ALU flag in,
//                datapath selects and write enables out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_multi_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] alu_control;

    modport master (
        input  op, funct, zero,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_control
    );

    modport slave (
        output op, funct, zero,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_control
    );
endinterface : mips_multi_control_if
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational map from (alu_op, funct) to the 3-bit ALU code.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_CTRL_ADD;
        case (i_alu_op)
            ALU_OP_ADD: o_alu_control = ALU_CTRL_ADD;
            ALU_OP_SUB: o_alu_control = ALU_CTRL_SUB;
            ALU_OP_FUNCT: begin
                // Unrecognised funct codes fall back to add.
                case (i_funct)
                    FUNCT_ADD: o_alu_control = ALU_CTRL_ADD;
                    FUNCT_SUB: o_alu_control = ALU_CTRL_SUB;
                    FUNCT_AND: o_alu_control = ALU_CTRL_AND;
                    FUNCT_OR:  o_alu_control = ALU_CTRL_OR;
                    FUNCT_SLT: o_alu_control = ALU_CTRL_SLT;
                    default:   o_alu_control = ALU_CTRL_ADD;
                endcase
            end
            default: o_alu_control = ALU_CTRL_ADD;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mips_multi_control.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multi_control
//  Description : Multicycle MIPS controller FSM; Moore-decoded datapath
//                controls plus the branch-qualified PC enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multi_control
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    mips_multi_control_if.master   ctrl
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    alu_op_t    w_alu_op;
    logic [2:0] w_alu_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (ctrl.op == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else if (ctrl.op == OP_SW) begin
                    w_next_state = S_MEMWR;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMRD:   w_next_state = S_MEMWB;
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            default:   w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = ALU_OP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_alu_src_b = 2'b01;
                w_pc_write  = 1'b1;
            end
            S_DECODE:  w_alu_src_b = 2'b11;
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD:   w_iord = 1'b1;
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_OP_SUB;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_ADDIWB:  w_reg_write = 1'b1;
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                w_ir_write  = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (ctrl.funct),
        .o_alu_control (w_alu_control)
    );

    // Write enables are held off while reset is asserted so no datapath
    // state changes on a reset edge racing the clock.
    assign ctrl.iord        = w_iord;
    assign ctrl.mem_write   = w_mem_write & ~reset;
    assign ctrl.ir_write    = w_ir_write & ~reset;
    assign ctrl.reg_dst     = w_reg_dst;
    assign ctrl.mem_to_reg  = w_mem_to_reg;
    assign ctrl.reg_write   = w_reg_write & ~reset;
    assign ctrl.alu_src_a   = w_alu_src_a;
    assign ctrl.alu_src_b   = w_alu_src_b;
    assign ctrl.pc_src      = w_pc_src;
    assign ctrl.pc_en       = (w_pc_write | (w_branch & ctrl.zero)) & ~reset;
    assign ctrl.alu_control = w_alu_control;

endmodule : mips_multi_control
`default_nettype wire

// File: tb/tb_mips_multi_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multi_control
//  Description : Self-checking bench for the multicycle MIPS controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multi_control;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mips_multi_control_if bus ();

    mips_multi_control dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    // Vector layout: iord, mem_write, ir_write, reg_dst, mem_to_reg,
    // reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0], pc_en, alu_control[2:0]
    function automatic logic [14:0] observed();
        return {bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.pc_src, bus.pc_en, bus.alu_control};
    endfunction

    function automatic logic [14:0] vec(logic iord, logic mw, logic irw,
                                        logic rd, logic m2r, logic rw,
                                        logic sa, logic [1:0] sb,
                                        logic [1:0] ps, logic pe,
                                        logic [2:0] ac);
        return {iord, mw, irw, rd, m2r, rw, sa, sb, ps, pe, ac};
    endfunction

    function automatic logic [2:0] funct_alu(logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int latency(logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected control vector for cycle k of an instruction (k=0 is FETCH).
    function automatic logic [14:0] expect_vec(logic [5:0] op, logic [5:0] funct,
                                               int k, logic z);
        logic [14:0] v;
        v = vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010);
        if (k == 0)      v = vec(0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 3'b010);
        else if (k == 1) v = vec(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010);
        else if (op == 6'b100011 || op == 6'b101011) begin
            if (k == 2)      v = vec(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010);
            else if (k == 3) v = vec(1, (op == 6'b101011), 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010);
            else             v = vec(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'b010);
        end else if (op == 6'b000000) begin
            if (k == 2) v = vec(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, funct_alu(funct));
            else        v = vec(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010);
        end else if (op == 6'b000100) begin
            v = vec(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, z, 3'b110);
        end else if (op == 6'b001000) begin
            if (k == 2) v = vec(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010);
            else        v = vec(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010);
        end else if (op == 6'b000010) begin
            v = vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b010);
        end
        return v;
    endfunction

    task automatic check(string tag, logic [14:0] obs, logic [14:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the controller in FETCH; ends at the negedge
    // of the next FETCH. zsel < 0 randomises zero every cycle.
    task automatic run_instr(logic [5:0] op, logic [5:0] funct, int zsel, string name);
        int lat;
        lat = latency(op);
        bus.op    = op;
        bus.funct = funct;
        for (int k = 0; k < lat; k++) begin
            bus.zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1;
            check($sformatf("%s op=%b f=%b c%0d", name, op, funct, k),
                  observed(), expect_vec(op, funct, k, bus.zero));
            @(negedge clk);
        end
    endtask

    localparam logic [14:0] RESET_VEC = 15'b000_0000_0100_0010;
    localparam logic [14:0] FETCH_VEC = 15'b001_0000_0100_1010;

    logic [5:0] rtype_functs [5] = '{6'b100000, 6'b100010, 6'b100100,
                                     6'b100101, 6'b101010};
    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b001000, 6'b000010};

    initial begin
        logic [5:0] rop;
        logic [5:0] rfn;

        reset    = 1'b1;
        bus.op   = 6'b100011;
        bus.funct = 6'b0;
        bus.zero = 1'b1;
        #2;
        check("reset_hold", observed(), RESET_VEC);
        @(negedge clk);
        @(negedge clk);
        check("reset_hold2", observed(), RESET_VEC);
        reset = 1'b0;
        #1;
        check("reset_release_fetch", observed(), FETCH_VEC);

        // lw interrupted by reset while in MEMWB
        for (int k = 0; k < 4; k++) begin
            bus.zero = 1'b1;
            #1;
            check($sformatf("lw_abort c%0d", k), observed(), expect_vec(6'b100011, 6'b0, k, 1'b1));
            @(negedge clk);
        end
        #1;
        check("lw_memwb", observed(), expect_vec(6'b100011, 6'b0, 4, 1'b1));
        reset = 1'b1;
        #1;
        check("reset_mid_memwb", observed(), RESET_VEC);
        @(posedge clk);
        #1;
        check("reset_mid_held", observed(), RESET_VEC);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_abort_fetch", observed(), FETCH_VEC);
        @(negedge clk);
        // That negedge crossed one rising edge: now in DECODE with op=lw.
        #1;
        check("after_abort_decode", observed(), expect_vec(6'b100011, 6'b0, 1, 1'b1));
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("after_abort_lw c%0d", k), observed(), expect_vec(6'b100011, 6'b0, k, 1'b1));
        end
        @(negedge clk);

        // Directed instructions
        run_instr(6'b100011, 6'b000000, -1, "lw");
        for (int i = 0; i < 5; i++) run_instr(6'b000000, rtype_functs[i], -1, "rtype");
        run_instr(6'b000000, 6'b000000, -1, "rtype_unlisted");
        run_instr(6'b000100, 6'b000000, 1, "beq_taken");
        run_instr(6'b000100, 6'b000000, 0, "beq_not_taken");
        run_instr(6'b101011, 6'b000000, -1, "sw");
        run_instr(6'b001000, 6'b000000, -1, "addi");
        run_instr(6'b000010, 6'b000000, -1, "j");
        run_instr(6'b111111, 6'b000000, -1, "illegal");

        // Randomised instruction stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 0) rop = 6'($urandom);
            else rop = legal_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 0) rfn = rtype_functs[$urandom_range(0, 4)];
            else rfn = 6'($urandom);
            run_instr(rop, rfn, -1, "random");
        end

        // Trailing FETCH confirms the last instruction's latency.
        #1;
        check("final_fetch", observed(), FETCH_VEC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mips_multi_control
`default_nettype wire
